// File: rtl/enokida_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : enokida_pkg
//  Description : Shared types for the Enokida memory-port arbiter. It holds
//                the requester identity stored in the owner FIFO and the
//                arbiter FSM state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package enokida_pkg;

  // Requester identity: port 0 is the cache miss/fill path, port 1 the
  // trace-driven prefetch/bypass path.
  typedef enum logic {
    OWNER_CACHE = 1'b0,
    OWNER_PREF  = 1'b1
  } owner_t;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } arb_state_t;

  // After a grant, round-robin favours the port that did not just win.
  function automatic owner_t other_owner(input owner_t o);
    return (o == OWNER_CACHE) ? OWNER_PREF : OWNER_CACHE;
  endfunction

endpackage
`default_nettype wire

// File: rtl/enokida_owner_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : enokida_owner_fifo
//  Description : Small FIFO of owner_t entries. It records which requester
//                owns each granted-but-unanswered memory transaction, in
//                grant order. Push and pop may occur in the same cycle.
//  Ports       : clk, rst (async, active-high)
//                push/push_id - enqueue an owner (ignored when full)
//                pop          - dequeue the head (ignored when empty)
//                head         - oldest owner; valid while !empty
//                full, empty  - occupancy flags
//                count        - occupancy, 0..DEPTH
//  Revision    : 1.0 - initial release
// ============================================================================
module enokida_owner_fifo
  import enokida_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  owner_t                 push_id,
  input  logic                   pop,
  output owner_t                 head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE  = (PTR_W)'(1);
  localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
  localparam logic [PTR_W:0]   FULL_CNT = (PTR_W+1)'(DEPTH);

  owner_t           slots [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = slots[rd_ptr];

  // DEPTH is a power of two, so the pointers wrap on natural overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        slots[i] <= OWNER_CACHE;
      end
    end else begin
      if (do_push) begin
        slots[wr_ptr] <= push_id;
        wr_ptr        <= wr_ptr + PTR_ONE;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/enokida_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : enokida_mem_arbiter
//  Description : Two-requester arbiter for the RI5CY-protocol data memory
//                port. Port 0 = cache miss/fill, port 1 = prefetch/bypass.
//                Round-robin selection, selection held until memory grants,
//                and responses routed back through an owner FIFO.
//  Ports       : p0_* / p1_*    - requester-side RI5CY data interfaces
//                mem_*          - memory-side RI5CY data interface
//                lock_i         - excludes port 1 from new arbitrations
//                outstanding_o  - granted-but-unanswered transaction count
//                protocol_err_o - sticky: owner dropped req in HOLD, or
//                                 rvalid arrived with nothing outstanding
//                pN_gnt_count_o - per-port accepted-grant counters (wrap)
//  Revision    : 1.0 - initial release
// ============================================================================
module enokida_mem_arbiter
  import enokida_pkg::*;
#(
  parameter int ADDR_WIDTH      = 16,
  parameter int DATA_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               p0_req_i,
  input  logic                               p0_we_i,
  input  logic [ADDR_WIDTH-1:0]              p0_addr_i,
  input  logic [DATA_WIDTH/8-1:0]            p0_be_i,
  input  logic [DATA_WIDTH-1:0]              p0_wdata_i,
  output logic                               p0_gnt_o,
  output logic                               p0_rvalid_o,
  output logic [DATA_WIDTH-1:0]              p0_rdata_o,
  input  logic                               p1_req_i,
  input  logic                               p1_we_i,
  input  logic [ADDR_WIDTH-1:0]              p1_addr_i,
  input  logic [DATA_WIDTH/8-1:0]            p1_be_i,
  input  logic [DATA_WIDTH-1:0]              p1_wdata_i,
  output logic                               p1_gnt_o,
  output logic                               p1_rvalid_o,
  output logic [DATA_WIDTH-1:0]              p1_rdata_o,
  output logic                               mem_req_o,
  output logic                               mem_we_o,
  output logic [ADDR_WIDTH-1:0]              mem_addr_o,
  output logic [DATA_WIDTH/8-1:0]            mem_be_o,
  output logic [DATA_WIDTH-1:0]              mem_wdata_o,
  input  logic                               mem_gnt_i,
  input  logic                               mem_rvalid_i,
  input  logic [DATA_WIDTH-1:0]              mem_rdata_i,
  input  logic                               lock_i,
  output logic [$clog2(MAX_OUTSTANDING):0]   outstanding_o,
  output logic                               protocol_err_o,
  output logic [31:0]                        p0_gnt_count_o,
  output logic [31:0]                        p1_gnt_count_o
);

  arb_state_t state, state_next;
  owner_t     rr;          // port favoured when both are eligible
  owner_t     held;        // owner latched while waiting for mem_gnt_i
  owner_t     held_next;
  owner_t     sel;
  logic       sel_valid;
  logic       elig0, elig1;
  logic       owner_req;
  logic       drop_err;
  logic       accept;
  logic       pop;
  logic       fifo_full, fifo_empty;
  owner_t     fifo_head;

  // Next-state and selection. Arbitration is suppressed while rst is high so
  // that an asynchronous reset silences mem_req_o immediately, even with a
  // requester still asserting req.
  always_comb begin
    state_next = state;
    held_next  = held;
    sel        = OWNER_CACHE;
    sel_valid  = 1'b0;
    drop_err   = 1'b0;
    elig0      = p0_req_i;
    elig1      = p1_req_i & ~lock_i;
    owner_req  = (held == OWNER_CACHE) ? p0_req_i : p1_req_i;
    case (state)
      IDLE: begin
        if (!rst && !fifo_full && (elig0 || elig1)) begin
          sel_valid = 1'b1;
          if (elig0 && elig1) sel = rr;
          else if (elig1)     sel = OWNER_PREF;
          else                sel = OWNER_CACHE;
          if (!mem_gnt_i) begin
            state_next = HOLD;
            held_next  = sel;
          end
        end
      end
      HOLD: begin
        // The held owner keeps the port regardless of lock_i or the other
        // requester; only the owner withdrawing its request releases it.
        sel = held;
        if (!owner_req) begin
          drop_err   = 1'b1;
          state_next = IDLE;
        end else if (!fifo_full) begin
          sel_valid = 1'b1;
          if (mem_gnt_i) state_next = IDLE;
        end
      end
    endcase
  end

  assign accept = sel_valid & mem_gnt_i;

  // Memory-side forwarding; data fields are zeroed when nothing is selected.
  always_comb begin
    mem_req_o   = sel_valid;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_be_o    = '0;
    mem_wdata_o = '0;
    if (sel_valid) begin
      if (sel == OWNER_CACHE) begin
        mem_we_o    = p0_we_i;
        mem_addr_o  = p0_addr_i;
        mem_be_o    = p0_be_i;
        mem_wdata_o = p0_wdata_i;
      end else begin
        mem_we_o    = p1_we_i;
        mem_addr_o  = p1_addr_i;
        mem_be_o    = p1_be_i;
        mem_wdata_o = p1_wdata_i;
      end
    end
  end

  assign p0_gnt_o = accept & (sel == OWNER_CACHE);
  assign p1_gnt_o = accept & (sel == OWNER_PREF);

  // Response routing: the FIFO head names the requester of the oldest
  // outstanding transaction. A response with nothing outstanding is dropped.
  assign pop         = mem_rvalid_i & ~fifo_empty;
  assign p0_rvalid_o = pop & (fifo_head == OWNER_CACHE);
  assign p1_rvalid_o = pop & (fifo_head == OWNER_PREF);
  assign p0_rdata_o  = mem_rdata_i;
  assign p1_rdata_o  = mem_rdata_i;

  enokida_owner_fifo #(
    .DEPTH (MAX_OUTSTANDING)
  ) u_owner_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (accept),
    .push_id (sel),
    .pop     (pop),
    .head    (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (outstanding_o)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      held           <= OWNER_CACHE;
      rr             <= OWNER_CACHE;
      protocol_err_o <= 1'b0;
      p0_gnt_count_o <= '0;
      p1_gnt_count_o <= '0;
    end else begin
      state <= state_next;
      held  <= held_next;
      if (accept) begin
        rr <= other_owner(sel);
        if (sel == OWNER_CACHE) p0_gnt_count_o <= p0_gnt_count_o + 32'd1;
        else                    p1_gnt_count_o <= p1_gnt_count_o + 32'd1;
      end
      if (drop_err || (mem_rvalid_i && fifo_empty)) begin
        protocol_err_o <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire
